// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit and its instruction queue.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [15:0] NO_PRED = 16'hFFFF;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] pc;
        logic        pred_taken;
        logic [15:0] pred_target;
    } fq_entry_t;

    // Follow the predictor when it has an opinion, otherwise fall through (wraps at 16'hFFFF).
    function automatic logic [15:0] next_fetch_pc(input logic [15:0] pc, input logic [15:0] pred);
        return (pred != NO_PRED) ? pred : (pc + 16'd1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Predictor, instruction-memory, redirect and decode-side signals of the fetch unit.
interface fetch_unit_if;

    logic        pred_request;
    logic [15:0] pred_pc;
    logic [15:0] pred_address;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [15:0] imem_data;

    logic        redirect;
    logic [15:0] redirect_pc;

    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_pred_taken;
    logic [15:0] inst_pred_target;

    modport master (
        output pred_request, pred_pc, imem_req, imem_addr,
               inst_valid, inst_data, inst_pc, inst_pred_taken, inst_pred_target,
        input  pred_address, imem_ready, imem_valid, imem_data,
               redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  pred_request, pred_pc, imem_req, imem_addr,
               inst_valid, inst_data, inst_pc, inst_pred_taken, inst_pred_target,
        output pred_address, imem_ready, imem_valid, imem_data,
               redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_unit_queue.sv
// Instruction queue between fetch and decode: circular buffer with push, pop and flush.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int   DEPTH = 4,
    localparam int  CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fq_entry_t        push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output fq_entry_t        head
);

    localparam int               PTR_W   = CNT_W - 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fq_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests so a full queue never overwrites and an empty one never underflows.
    always_comb begin
        do_push_s = push && (count_r != DEPTH_C);
        do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
    end

    // Storage, pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count      = count_r;
    assign head_valid = (count_r != {CNT_W{1'b0}});
    assign head       = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one memory read at a time, consults the branch predictor
// on issue, and queues returned instructions for decode; redirects flush everything.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_unit_if.master    bus
);

    localparam int               CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    fetch_state_t     state_r;
    logic [15:0]      pc_r;
    logic [15:0]      lat_pc_r;
    logic             lat_taken_r;
    logic [15:0]      lat_target_r;

    logic             req_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             flush_s;
    fq_entry_t        push_entry_s;
    fq_entry_t        head_s;
    logic             head_valid_s;
    logic [CNT_W-1:0] q_count_s;

    // Request only from FETCH with queue room; reset and redirect gate it in the same cycle.
    always_comb begin
        req_s = 1'b0;
        case (state_r)
            FETCH: begin
                if (rst_n && (q_count_s < DEPTH_C) && !bus.redirect) begin
                    req_s = 1'b1;
                end else begin
                    req_s = 1'b0;
                end
            end
            default: req_s = 1'b0;
        endcase
    end

    // Queue control; a response arriving together with a redirect is dropped by the flush.
    always_comb begin
        accept_s     = req_s && bus.imem_ready;
        push_s       = (state_r == WAIT) && bus.imem_valid && !bus.redirect;
        flush_s      = bus.redirect;
        pop_s        = head_valid_s && bus.inst_ready;
        push_entry_s = '{data:        bus.imem_data,
                         pc:          lat_pc_r,
                         pred_taken:  lat_taken_r,
                         pred_target: lat_target_r};
    end

    // Fetch sequencing: FETCH issues, WAIT collects the response, DRAIN swallows a stale one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= FETCH;
            pc_r         <= RESET_PC;
            lat_pc_r     <= 16'h0000;
            lat_taken_r  <= 1'b0;
            lat_target_r <= 16'h0000;
        end else begin
            case (state_r)
                FETCH: begin
                    if (bus.redirect) begin
                        pc_r <= bus.redirect_pc;
                    end else if (accept_s) begin
                        lat_pc_r     <= pc_r;
                        lat_taken_r  <= (bus.pred_address != NO_PRED);
                        lat_target_r <= bus.pred_address;
                        pc_r         <= next_fetch_pc(pc_r, bus.pred_address);
                        state_r      <= WAIT;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                WAIT: begin
                    if (bus.redirect) begin
                        pc_r    <= bus.redirect_pc;
                        state_r <= bus.imem_valid ? FETCH : DRAIN;
                    end else if (bus.imem_valid) begin
                        state_r <= FETCH;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DRAIN: begin
                    if (bus.redirect) begin
                        pc_r <= bus.redirect_pc;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (bus.imem_valid) begin
                        state_r <= FETCH;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: state_r <= FETCH;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (flush_s),
        .count      (q_count_s),
        .head_valid (head_valid_s),
        .head       (head_s)
    );

    assign bus.imem_req         = req_s;
    assign bus.pred_request     = req_s;
    assign bus.imem_addr        = pc_r;
    assign bus.pred_pc          = pc_r;
    assign bus.inst_valid       = head_valid_s;
    assign bus.inst_data        = head_s.data;
    assign bus.inst_pc          = head_s.pc;
    assign bus.inst_pred_taken  = head_s.pred_taken;
    assign bus.inst_pred_target = head_s.pred_target;

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: expected fetch PC, expected queue contents and the memory's outstanding read.
    fq_entry_t   mq[$];
    logic [15:0] m_pc;
    bit          pend;
    bit          discard;
    int          cnt;
    fq_entry_t   lat;
    logic [15:0] acc_log[$];

    int ready_pct = 100, irdy_pct = 100, rd_pct = 0, pred_pct = 0, lat_min = 1, lat_max = 1;
    logic [15:0] pred_tab [logic [15:0]];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] acc_at(input int i);
        return (acc_log.size() > i) ? acc_log[i] : 16'hDEAD;
    endfunction

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.imem_ready   = 1'b0;
        bus.imem_valid   = 1'b0;
        bus.imem_data    = 16'h0000;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 16'h0000;
        bus.inst_ready   = 1'b0;
        bus.pred_address = NO_PRED;
        #1;
        chk("rst_imem_req", 16'(bus.imem_req), 16'h0000);
        chk("rst_pred_request", 16'(bus.pred_request), 16'h0000);
        chk("rst_inst_valid", 16'(bus.inst_valid), 16'h0000);
        chk("rst_inst_data", bus.inst_data, 16'h0000);
        chk("rst_inst_pc", bus.inst_pc, 16'h0000);
        chk("rst_inst_pred_taken", 16'(bus.inst_pred_taken), 16'h0000);
        chk("rst_inst_pred_target", bus.inst_pred_target, 16'h0000);
        chk("rst_imem_addr", bus.imem_addr, RST_PC);
        repeat (2) @(negedge clk);
        mq.delete();
        pend    = 1'b0;
        discard = 1'b0;
        m_pc    = RST_PC;
        rst_n   = 1'b1;
    endtask

    // One clock: drive inputs at the falling edge, check outputs, advance the model across the edge.
    task automatic step(input bit f_rd, input logic [15:0] f_pc);
        bit          rd, rdy, ir, vld, exp_req;
        logic [15:0] rpc, pa;
        vld = pend && (cnt == 0);
        rd  = f_rd || ($urandom_range(99) < rd_pct);
        rpc = f_rd ? f_pc : 16'($urandom);
        rdy = ($urandom_range(99) < ready_pct);
        ir  = ($urandom_range(99) < irdy_pct);
        bus.imem_valid  = vld;
        bus.imem_data   = vld ? lat.data : 16'($urandom);
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_ready  = rdy;
        bus.inst_ready  = ir;
        if (pred_tab.exists(bus.pred_pc)) pa = pred_tab[bus.pred_pc];
        else if ($urandom_range(99) < pred_pct) pa = 16'($urandom);
        else pa = NO_PRED;
        bus.pred_address = pa;
        #1;
        exp_req = !pend && (mq.size() < DEPTH) && !rd;
        chk("imem_req", 16'(bus.imem_req), 16'(exp_req));
        chk("pred_request", 16'(bus.pred_request), 16'(exp_req));
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("pred_pc", bus.pred_pc, m_pc);
        chk("inst_valid", 16'(bus.inst_valid), 16'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("inst_data", bus.inst_data, mq[0].data);
            chk("inst_pc", bus.inst_pc, mq[0].pc);
            chk("inst_pred_taken", 16'(bus.inst_pred_taken), 16'(mq[0].pred_taken));
            chk("inst_pred_target", bus.inst_pred_target, mq[0].pred_target);
        end
        if (pend && !vld) cnt--;
        if (mq.size() > 0 && ir && !rd) void'(mq.pop_front());
        if (rd) begin
            mq.delete();
            m_pc = rpc;
            if (pend && vld) begin
                pend    = 1'b0;
                discard = 1'b0;
            end else if (pend) begin
                discard = 1'b1;
            end
        end else if (pend && vld) begin
            if (!discard) mq.push_back(lat);
            pend    = 1'b0;
            discard = 1'b0;
        end else if (!pend && exp_req && rdy) begin
            lat.pc          = m_pc;
            lat.pred_taken  = (pa != NO_PRED);
            lat.pred_target = pa;
            lat.data        = 16'($urandom);
            acc_log.push_back(m_pc);
            m_pc = (pa != NO_PRED) ? pa : m_pc + 16'd1;
            pend = 1'b1;
            cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        step(1'b0, 16'h0000);
    endtask

    task automatic wait_pend();
        for (int i = 0; i < 20; i++) begin
            if (pend) break;
            cyc();
        end
        chk("wait_pend_timeout", 16'(pend), 16'h0001);
    endtask

    initial begin
        do_reset();

        // Sequential fetch with no predictions, 1-cycle memory.
        repeat (6) cyc();
        chk("seq_addr0", acc_at(0), 16'h0000);
        chk("seq_addr1", acc_at(1), 16'h0001);
        chk("seq_addr2", acc_at(2), 16'h0002);

        // Predicted-taken at 0003 steers the next fetch to 0040.
        pred_tab[16'h0003] = 16'h0040;
        repeat (6) cyc();
        chk("pred_addr3", acc_at(3), 16'h0003);
        chk("pred_target_fetch", acc_at(4), 16'h0040);
        pred_tab.delete();

        // Decode stalled: exactly DEPTH fetches, then one pop allows one more.
        do_reset();
        acc_log.delete();
        irdy_pct = 0;
        repeat (30) cyc();
        chk("full_accepts", 16'(acc_log.size()), 16'(DEPTH));
        #1;
        chk("full_req_low", 16'(bus.imem_req), 16'h0000);
        irdy_pct = 100;
        cyc();
        irdy_pct = 0;
        repeat (10) cyc();
        chk("pop_refetch", 16'(acc_log.size()), 16'(DEPTH + 1));
        irdy_pct = 100;

        // Redirect while waiting on a slow response.
        do_reset();
        lat_min = 3; lat_max = 3;
        wait_pend();
        step(1'b1, 16'h0100);
        acc_log.delete();
        repeat (8) cyc();
        chk("wait_redirect_addr", acc_at(0), 16'h0100);

        // Redirect coincident with the response of the fetch at FFFF.
        lat_min = 1; lat_max = 1;
        acc_log.delete();
        step(1'b1, 16'hFFFF);
        for (int i = 0; i < 10; i++) begin
            if (pend && acc_log.size() > 0 && acc_log[acc_log.size() - 1] == 16'hFFFF) break;
            cyc();
        end
        chk("ffff_issued", 16'(pend), 16'h0001);
        step(1'b1, 16'h0200);
        acc_log.delete();
        repeat (4) cyc();
        chk("same_cycle_redirect_addr", acc_at(0), 16'h0200);

        // FFFF falls through to 0000.
        acc_log.delete();
        step(1'b1, 16'hFFFF);
        repeat (8) cyc();
        chk("wrap_ffff", acc_at(0), 16'hFFFF);
        chk("wrap_0000", acc_at(1), 16'h0000);

        // Reset in the middle of an outstanding read.
        lat_min = 3; lat_max = 3;
        wait_pend();
        do_reset();
        acc_log.delete();
        repeat (3) cyc();
        chk("mid_wait_reset_addr", acc_at(0), RST_PC);

        // Random traffic.
        ready_pct = 70; irdy_pct = 60; rd_pct = 5; pred_pct = 20; lat_min = 1; lat_max = 3;
        repeat (3000) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
